// File: rtl/l1_dm_cache.sv
// l1_dm_cache: direct-mapped, write-back, write-allocate L1 cache.
// It serves the CPU word interface and moves whole 256-bit lines to and from
// the next memory level.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   mem_read, mem_write      CPU request, held until mem_resp (both high = write)
//   mem_address              CPU byte address; bits [1:0] are ignored
//   mem_byte_enable          write byte lanes
//   mem_wdata                lane-aligned write data
//   mem_resp, mem_rdata      one-cycle completion pulse and the read word
//   pmem_read, pmem_write    line fill / writeback request, held until pmem_resp
//   pmem_address             line address, low 5 bits zero
//   pmem_wdata               writeback line
//   pmem_resp, pmem_rdata    line completion pulse and the fill line
module l1_dm_cache #(
  parameter int unsigned S_INDEX  = 3,
  parameter int unsigned S_OFFSET = 5,
  parameter int unsigned S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata
);

  localparam int unsigned NUM_LINES  = 1 << S_INDEX;
  localparam int unsigned LINE_W     = 256;
  localparam int unsigned WORD_SEL_W = S_OFFSET - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Line state
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [S_TAG-1:0]     tag_arr_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr_q [NUM_LINES];

  // Request address captured when a miss leaves IDLE
  logic [S_TAG-1:0]   tag_lat_q;
  logic [S_INDEX-1:0] idx_lat_q;
  logic               lat_load;

  // Registered outputs
  logic               mem_resp_q, mem_resp_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic               pmem_read_q, pmem_read_d;
  logic               pmem_write_q, pmem_write_d;
  logic [31:0]        pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0]  pmem_wdata_q, pmem_wdata_d;

  // Array write strobes
  logic fill_we;
  logic hit_we;

  // Address decode
  logic [S_TAG-1:0]      req_tag, cur_tag;
  logic [S_INDEX-1:0]    req_idx, cur_idx;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  req, hit;
  logic [LINE_W-1:0]     sel_line, wr_line;
  logic [31:0]           rd_word;
  logic                  unused_addr_bits;

  assign req_tag  = mem_address[31 -: S_TAG];
  assign req_idx  = mem_address[S_OFFSET +: S_INDEX];
  assign req_word = mem_address[2 +: WORD_SEL_W];
  assign unused_addr_bits = ^mem_address[1:0];

  // In IDLE the live address is decoded; during a miss the latched one is used
  assign cur_tag = (state_q == IDLE) ? req_tag : tag_lat_q;
  assign cur_idx = (state_q == IDLE) ? req_idx : idx_lat_q;

  assign req      = mem_read | mem_write;
  assign hit      = valid_q[cur_idx] & (tag_arr_q[cur_idx] == cur_tag);
  assign sel_line = data_arr_q[cur_idx];
  assign rd_word  = sel_line[32'(req_word) * 32 +: 32];

  // Selected line with the enabled write lanes merged in
  always_comb begin
    wr_line = sel_line;
    for (int i = 0; i < 4; i++) begin
      if (mem_byte_enable[i]) begin
        wr_line[32'(req_word) * 32 + 32'(i) * 8 +: 8] = mem_wdata[i*8 +: 8];
      end
    end
  end

  // Next state, line-state updates and next output values
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    lat_load       = 1'b0;
    fill_we        = 1'b0;
    hit_we         = 1'b0;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = 1'b0;
    pmem_write_d   = 1'b0;
    pmem_address_d = '0;
    pmem_wdata_d   = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          lat_load = 1'b1;
          if (hit) begin
            state_d = RESP;
            if (mem_write) begin
              if (|mem_byte_enable) begin
                hit_we           = 1'b1;
                dirty_d[cur_idx] = 1'b1;
              end
            end else begin
              mem_rdata_d = rd_word;
            end
          end else if (valid_q[cur_idx] & dirty_q[cur_idx]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          dirty_d[cur_idx] = 1'b0;
          state_d          = FILL;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          fill_we          = 1'b1;
          valid_d[cur_idx] = 1'b1;
          dirty_d[cur_idx] = 1'b0;
          state_d          = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are registered with it
    mem_resp_d = (state_d == RESP);
    case (state_d)
      WRITEBACK: begin
        pmem_write_d   = 1'b1;
        pmem_address_d = {tag_arr_q[cur_idx], cur_idx, {S_OFFSET{1'b0}}};
        pmem_wdata_d   = sel_line;
      end
      FILL: begin
        pmem_read_d    = 1'b1;
        pmem_address_d = {cur_tag, cur_idx, {S_OFFSET{1'b0}}};
      end
      default: begin
      end
    endcase
  end

  // State, line-state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      tag_lat_q      <= '0;
      idx_lat_q      <= '0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      if (lat_load) begin
        tag_lat_q <= req_tag;
        idx_lat_q <= req_idx;
      end
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_arr_q[cur_idx] <= pmem_rdata;
      tag_arr_q[cur_idx]  <= cur_tag;
    end else if (hit_we) begin
      data_arr_q[cur_idx] <= wr_line;
    end
  end

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_l1_dm_cache.sv
// Directed testbench for l1_dm_cache with a line-level memory responder.
module tb_l1_dm_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  always #5 clk = ~clk;

  l1_dm_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Memory model state
  int           lat = 5;
  int           rd_txn = 0, wr_txn = 0, seq = 0, rd_seq = 0, wb_seq = 0;
  int           resp_cnt = 0, overlap_cnt = 0;
  logic [31:0]  last_rd_addr = '0, last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;
  logic [255:0] mem_store [logic [31:0]];

  // Lines not explicitly stored hold word k = {addr[15:0], k}
  function automatic logic [255:0] line_for(input logic [31:0] a);
    logic [255:0] l;
    if (mem_store.exists(a)) return mem_store[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[15:0], 16'(k)};
    return l;
  endfunction

  // Line memory: answers after 'lat' cycles of a held request
  initial begin
    int cnt;
    cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst_n !== 1'b1) begin
        cnt = 0;
      end else if (pmem_read === 1'b1 || pmem_write === 1'b1) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          seq++;
          if (pmem_write === 1'b1) begin
            wr_txn++;
            wb_seq       = seq;
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
            mem_store[pmem_address] = pmem_wdata;
          end else begin
            rd_txn++;
            rd_seq       = seq;
            last_rd_addr = pmem_address;
            pmem_rdata   = line_for(pmem_address);
          end
          pmem_resp = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Event counters
  always @(negedge clk) begin
    if (mem_resp === 1'b1) resp_cnt++;
    if (pmem_read === 1'b1 && pmem_write === 1'b1) overlap_cnt++;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // One CPU access; cyc = negedges from drive until mem_resp is seen
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rdata, output int cyc);
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a;
    mem_byte_enable = be; mem_wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (mem_resp !== 1'b1 && cyc < 200);
    rdata = mem_rdata;
    checks++;
    if (mem_resp !== 1'b1) begin
      errors++;
      $display("FAIL access_timeout addr %h got resp %b want 1", a, mem_resp);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_byte_enable = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp got %b want 0", mem_resp); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got %b want 0", pmem_write); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); end
    checks++; if (pmem_address !== 32'h0) begin errors++; $display("FAIL reset_pmem_address got %h want 0", pmem_address); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cold_miss();
    int r0, w0, c0, cyc;
    logic [31:0] rd;
    lat = 5; r0 = rd_txn; w0 = wr_txn; c0 = resp_cnt;
    access(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, rd, cyc);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cold_rdata got %h want deadbeef", rd); end
    checks++; if (cyc !== 7) begin errors++; $display("FAIL cold_latency got %0d want 7", cyc); end
    checks++; if (rd_txn - r0 !== 1) begin errors++; $display("FAIL cold_fill_count got %0d want 1", rd_txn - r0); end
    checks++; if (last_rd_addr !== 32'h40) begin errors++; $display("FAIL cold_fill_addr got %h want 40", last_rd_addr); end
    checks++; if (wr_txn !== w0) begin errors++; $display("FAIL cold_no_wb got %0d want %0d", wr_txn, w0); end
    checks++; if (resp_cnt - c0 !== 1) begin errors++; $display("FAIL cold_resp_count got %0d want 1", resp_cnt - c0); end
    r0 = rd_txn;
    access(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL hit_latency got %0d want 1", cyc); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_rdata got %h want deadbeef", rd); end
    checks++; if (rd_txn !== r0) begin errors++; $display("FAIL hit_no_fill got %0d want %0d", rd_txn, r0); end
  endtask

  task automatic test_byte_write();
    int r0, w0, cyc;
    logic [31:0] rd;
    r0 = rd_txn; w0 = wr_txn;
    access(1'b0, 1'b1, 32'h44, 4'b0110, 32'h1122_3344, rd, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL bw_latency got %0d want 1", cyc); end
    access(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, rd, cyc);
    checks++; if (rd !== 32'hAA22_33AA) begin errors++; $display("FAIL bw_rdata got %h want aa2233aa", rd); end
    access(1'b0, 1'b1, 32'h48, 4'b0000, 32'hFFFF_FFFF, rd, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL be0_latency got %0d want 1", cyc); end
    access(1'b1, 1'b0, 32'h48, 4'h0, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h4000_0002) begin errors++; $display("FAIL be0_rdata got %h want 40000002", rd); end
    access(1'b1, 1'b1, 32'h4C, 4'b1111, 32'h5555_AAAA, rd, cyc);
    access(1'b1, 1'b0, 32'h4C, 4'h0, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h5555_AAAA) begin errors++; $display("FAIL rw_as_write got %h want 5555aaaa", rd); end
    checks++; if (rd_txn !== r0 || wr_txn !== w0) begin errors++; $display("FAIL bw_no_pmem got %0d/%0d want %0d/%0d", rd_txn, wr_txn, r0, w0); end
  endtask

  task automatic test_dirty_evict();
    int r0, w0, cyc;
    logic [31:0]  rd;
    logic [255:0] exp;
    exp = '0;
    exp[31:0]   = 32'hDEAD_BEEF;
    exp[63:32]  = 32'hAA22_33AA;
    exp[95:64]  = 32'h4000_0002;
    exp[127:96] = 32'h5555_AAAA;
    for (int k = 4; k < 8; k++) exp[k*32 +: 32] = 32'h4000_0000 + 32'(k);
    lat = 3; r0 = rd_txn; w0 = wr_txn;
    access(1'b1, 1'b0, 32'h140, 4'h0, 32'h0, rd, cyc);
    checks++; if (wr_txn - w0 !== 1) begin errors++; $display("FAIL evict_wb_count got %0d want 1", wr_txn - w0); end
    checks++; if (last_wb_addr !== 32'h40) begin errors++; $display("FAIL evict_wb_addr got %h want 40", last_wb_addr); end
    checks++; if (last_wb_data !== exp) begin errors++; $display("FAIL evict_wb_data got %h want %h", last_wb_data, exp); end
    checks++; if (rd_txn - r0 !== 1) begin errors++; $display("FAIL evict_fill_count got %0d want 1", rd_txn - r0); end
    checks++; if (last_rd_addr !== 32'h140) begin errors++; $display("FAIL evict_fill_addr got %h want 140", last_rd_addr); end
    checks++; if (!(wb_seq < rd_seq)) begin errors++; $display("FAIL evict_order got wb %0d rd %0d want wb first", wb_seq, rd_seq); end
    checks++; if (rd !== 32'h0140_0000) begin errors++; $display("FAIL evict_rdata got %h want 01400000", rd); end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL evict_latency got %0d want 8", cyc); end
  endtask

  task automatic test_clean_conflict();
    int r0, w0, cyc;
    logic [31:0] rd;
    lat = 2; r0 = rd_txn; w0 = wr_txn;
    access(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, rd, cyc);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL clean_rdata40 got %h want deadbeef", rd); end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL clean_latency got %0d want 4", cyc); end
    access(1'b1, 1'b0, 32'h140, 4'h0, 32'h0, rd, cyc);
    checks++; if (rd !== 32'h0140_0000) begin errors++; $display("FAIL clean_rdata140 got %h want 01400000", rd); end
    checks++; if (last_rd_addr !== 32'h140) begin errors++; $display("FAIL clean_fill_addr got %h want 140", last_rd_addr); end
    checks++; if (rd_txn - r0 !== 2) begin errors++; $display("FAIL clean_fill_count got %0d want 2", rd_txn - r0); end
    checks++; if (wr_txn !== w0) begin errors++; $display("FAIL clean_no_wb got %0d want %0d", wr_txn, w0); end
  endtask

  task automatic test_drop_mid_fill();
    int r0, c0, n, cyc;
    logic [31:0] rd;
    lat = 6; r0 = rd_txn; c0 = resp_cnt;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h80;
    n = 0;
    do begin @(negedge clk); n++; end while (pmem_read !== 1'b1 && n < 50);
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 32'h80) begin errors++; $display("FAIL drop_fill_req got %b/%h want 1/80", pmem_read, pmem_address); end
    mem_read = 1'b0;
    n = 0;
    while (rd_txn == r0 && n < 50) begin @(negedge clk); n++; end
    checks++; if (rd_txn !== r0 + 1) begin errors++; $display("FAIL drop_fill_done got %0d want %0d", rd_txn, r0 + 1); end
    repeat (4) @(negedge clk);
    checks++; if (resp_cnt !== c0) begin errors++; $display("FAIL drop_no_resp got %0d want %0d", resp_cnt, c0); end
    access(1'b1, 1'b0, 32'h80, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL drop_hit_latency got %0d want 1", cyc); end
    checks++; if (rd !== 32'h0080_0000) begin errors++; $display("FAIL drop_rdata got %h want 00800000", rd); end
    checks++; if (rd_txn !== r0 + 1) begin errors++; $display("FAIL drop_no_refill got %0d want %0d", rd_txn, r0 + 1); end
  endtask

  task automatic test_async_reset_wb();
    int r0, w0, n, cyc;
    logic [31:0] rd;
    lat = 2;
    access(1'b0, 1'b1, 32'h140, 4'b1111, 32'h1234_5678, rd, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL ar_write_hit got %0d want 1", cyc); end
    lat = 20; w0 = wr_txn;
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h240;
    n = 0;
    do begin @(negedge clk); n++; end while (pmem_write !== 1'b1 && n < 50);
    checks++; if (pmem_write !== 1'b1 || pmem_address !== 32'h140) begin errors++; $display("FAIL ar_wb_req got %b/%h want 1/140", pmem_write, pmem_address); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL ar_pmem_write_drop got %b want 0", pmem_write); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL ar_pmem_read got %b want 0", pmem_read); end
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lat = 2; r0 = rd_txn;
    access(1'b1, 1'b0, 32'h140, 4'h0, 32'h0, rd, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL ar_miss_latency got %0d want 4", cyc); end
    checks++; if (rd !== 32'h0140_0000) begin errors++; $display("FAIL ar_rdata got %h want 01400000", rd); end
    checks++; if (rd_txn - r0 !== 1) begin errors++; $display("FAIL ar_refill got %0d want 1", rd_txn - r0); end
    checks++; if (wr_txn !== w0) begin errors++; $display("FAIL ar_no_wb got %0d want %0d", wr_txn, w0); end
  endtask

  task automatic test_no_overlap();
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL pmem_overlap got %0d want 0", overlap_cnt); end
  endtask

  initial begin
    logic [255:0] pre;
    pre = '0;
    pre[31:0]  = 32'hDEAD_BEEF;
    pre[63:32] = 32'hAAAA_AAAA;
    for (int k = 2; k < 8; k++) pre[k*32 +: 32] = 32'h4000_0000 + 32'(k);
    mem_store[32'h40] = pre;

    test_reset();
    test_cold_miss();
    test_byte_write();
    test_dirty_evict();
    test_clean_conflict();
    test_drop_mid_fill();
    test_async_reset_wb();
    test_no_overlap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
